// File: rtl/mat_pkg.sv
// Shared constants, FSM encoding and packing helper for the sequential matrix multiplier.
// Elements are packed row-major at (row*DIM+col)*ELEM_W on every DIM*DIM*ELEM_W bus.
package mat_pkg;

    localparam int DIM      = 5;
    localparam int ELEM_W   = 8;
    localparam int ACC_W    = 19;
    localparam int PACKED_W = DIM * DIM * ELEM_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_MAC   = 2'd1;
    localparam logic [1:0] ST_STORE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic signed [ACC_W-1:0] ELEM_MAX = 19'sd127;
    localparam logic signed [ACC_W-1:0] ELEM_MIN = -19'sd128;

    function automatic logic [7:0] elem_off(input logic [2:0] row, input logic [2:0] col);
        elem_off = 8'((32'(row) * 32'(DIM) + 32'(col)) * 32'(ELEM_W));
    endfunction

endpackage

// File: rtl/mat_mac_unit.sv
// Signed ELEM_W x ELEM_W multiply into a registered ACC_W accumulator; one MAC per enabled edge.
// clr has priority over en; no backpressure, result visible the cycle after the edge.
module mat_mac_unit
    import mat_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [ELEM_W-1:0] a_i,
    input  logic signed [ELEM_W-1:0] b_i,
    output logic signed [ACC_W-1:0]  acc_o
);

    logic signed [2*ELEM_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;

    // Both operands signed, so -128 * -128 yields +16384 rather than a mis-signed value.
    assign prod = a_i * b_i;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACC_W-2*ELEM_W){prod[2*ELEM_W-1]}}, prod};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Sequential NxN (N<=5) signed 8-bit matrix multiply through one shared MAC; done after N*N*(N+1) edges.
// start is only accepted in IDLE; no queuing, operands are latched at acceptance.
module matrix_mult_sequencer
    import mat_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [2:0]          size,
    input  logic [PACKED_W-1:0] matrix_a,
    input  logic [PACKED_W-1:0] matrix_b,
    output logic [PACKED_W-1:0] result_out,
    output logic                overflow_flag,
    output logic                busy,
    output logic                done
);

    logic [1:0]          state_q, state_d;
    logic [2:0]          i_q, i_d;
    logic [2:0]          j_q, j_d;
    logic [2:0]          k_q, k_d;
    logic [2:0]          n_q, n_d;
    logic [PACKED_W-1:0] a_q, a_d;
    logic [PACKED_W-1:0] b_q, b_d;
    logic [PACKED_W-1:0] result_q, result_d;
    logic                ovf_q, ovf_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                    mac_clr;
    logic                    mac_en;
    logic signed [ACC_W-1:0] mac_acc;
    logic [2:0]              n_eff;
    logic                    last_k;
    logic                    last_j;
    logic                    last_i;

    assign n_eff  = (size == 3'd0 || size > 3'(DIM)) ? 3'(DIM) : size;
    assign last_k = (k_q == n_q - 3'd1);
    assign last_j = (j_q == n_q - 3'd1);
    assign last_i = (i_q == n_q - 3'd1);

    mat_mac_unit u_mac (
        .clk   (clk),
        .reset (reset),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (a_q[elem_off(i_q, k_q) +: ELEM_W]),
        .b_i   (b_q[elem_off(k_q, j_q) +: ELEM_W]),
        .acc_o (mac_acc)
    );

    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        k_d      = k_q;
        n_d      = n_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mac_clr  = 1'b0;
        mac_en   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = matrix_a;
                    b_d      = matrix_b;
                    n_d      = n_eff;
                    result_d = '0;
                    ovf_d    = 1'b0;
                    i_d      = '0;
                    j_d      = '0;
                    k_d      = '0;
                    mac_clr  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = ST_MAC;
                end
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (last_k) begin
                    k_d     = '0;
                    state_d = ST_STORE;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            ST_STORE: begin
                // Stored byte wraps; the out-of-range condition is reported via the sticky flag.
                result_d[elem_off(i_q, j_q) +: ELEM_W] = mac_acc[ELEM_W-1:0];
                if (mac_acc > ELEM_MAX || mac_acc < ELEM_MIN) begin
                    ovf_d = 1'b1;
                end
                mac_clr = 1'b1;
                k_d     = '0;
                if (last_j) begin
                    j_d = '0;
                    i_d = i_q + 3'd1;
                end else begin
                    j_d = j_q + 3'd1;
                end
                if (last_i && last_j) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MAC;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            n_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            n_q      <= n_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result_out    = result_q;
    assign overflow_flag = ovf_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Directed bench for matrix_mult_sequencer: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares on every done pulse.
module tb_matrix_mult_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   size;
    logic [199:0] matrix_a;
    logic [199:0] matrix_b;
    logic [199:0] result_out;
    logic         overflow_flag;
    logic         busy;
    logic         done;

    matrix_mult_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .size          (size),
        .matrix_a      (matrix_a),
        .matrix_b      (matrix_b),
        .result_out    (result_out),
        .overflow_flag (overflow_flag),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [199:0] res;
        logic         ovf;
        int           lat;
        int           start_edge;
        string        name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   bad_busy = 0;

    task automatic check(input string name, input logic [199:0] act, input logic [199:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic [199:0] put(input logic [199:0] bus, input int r, input int c,
                                         input logic [7:0] v);
        logic [199:0] t;
        t = bus;
        t[r*40 + c*8 +: 8] = v;
        return t;
    endfunction

    // Monitor: pops one expectation per done pulse, tracks busy while a job is in flight.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            if (!done && !busy) bad_busy++;
            if (done) begin
                mon_e = sb.pop_front();
                check({mon_e.name, " result"}, result_out, mon_e.res);
                check({mon_e.name, " overflow"}, 200'(overflow_flag), 200'(mon_e.ovf));
                check({mon_e.name, " latency"}, 200'(cyc - mon_e.start_edge), 200'(mon_e.lat));
                check({mon_e.name, " busy_drop"}, 200'(bad_busy), 200'(0));
                check({mon_e.name, " busy_at_done"}, 200'(busy), 200'(0));
            end
        end else if (done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: got done=1 required done=0");
        end
    end

    int start_edge;

    task automatic launch(input string name, input logic [199:0] a, input logic [199:0] b,
                          input logic [2:0] sz, input logic [199:0] exp_res,
                          input logic exp_ovf, input int exp_lat);
        exp_t e;
        @(negedge clk);
        matrix_a = a;
        matrix_b = b;
        size     = sz;
        start    = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        start_edge = cyc;
        bad_busy   = 0;
        e.res = exp_res; e.ovf = exp_ovf; e.lat = exp_lat; e.start_edge = cyc; e.name = name;
        sb.push_back(e);
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got no done within 400 cycles required done", name);
            sb.delete();
        end
    endtask

    task automatic wait_edge(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    logic [199:0] ident, btest, all127, res05;
    logic [199:0] a2, b2, r2, a1, b1, r1, a3, b3, r3;

    initial begin
        reset = 1'b1; start = 1'b1; size = 3'd5; matrix_a = '1; matrix_b = '1;

        ident = '0; btest = '0;
        for (int d = 0; d < 5; d++) ident = put(ident, d, d, 8'h01);
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) btest = put(btest, r, c, 8'(r*37 + c*11 - 60));
        btest  = put(btest, 0, 0, 8'h80);
        btest  = put(btest, 4, 4, 8'h7F);
        all127 = {25{8'h7F}};
        res05  = {25{8'h05}};

        a2 = '0; b2 = '0; r2 = '0;
        a2 = put(a2, 0, 0, 8'd1); a2 = put(a2, 0, 1, 8'd2); a2 = put(a2, 1, 0, 8'd3); a2 = put(a2, 1, 1, 8'd4);
        b2 = put(b2, 0, 0, 8'd5); b2 = put(b2, 0, 1, 8'd6); b2 = put(b2, 1, 0, 8'd7); b2 = put(b2, 1, 1, 8'd8);
        r2 = put(r2, 0, 0, 8'd19); r2 = put(r2, 0, 1, 8'd22); r2 = put(r2, 1, 0, 8'd43); r2 = put(r2, 1, 1, 8'd50);
        // Stray operand bytes outside the 2x2 window must be ignored.
        a2 = put(a2, 4, 4, 8'h55); b2 = put(b2, 2, 3, 8'h80);

        a1 = '0; b1 = '0; r1 = '0;
        for (int d = 0; d < 5; d++) begin
            a1 = put(a1, d, d, 8'h80);
            b1 = put(b1, d, d, 8'hFF);
        end
        r1 = put(r1, 0, 0, 8'h80);

        // A=[[1,-2,3],[0,4,-1],[-128,0,2]], B=[[2,0,1],[1,1,0],[0,-1,5]]
        // C=[[0,-5,16],[4,5,-5],[-256,-2,-118]]
        a3 = '0; b3 = '0; r3 = '0;
        a3 = put(a3, 0, 0, 8'd1);   a3 = put(a3, 0, 1, 8'hFE); a3 = put(a3, 0, 2, 8'd3);
        a3 = put(a3, 1, 1, 8'd4);   a3 = put(a3, 1, 2, 8'hFF);
        a3 = put(a3, 2, 0, 8'h80);  a3 = put(a3, 2, 2, 8'd2);
        b3 = put(b3, 0, 0, 8'd2);   b3 = put(b3, 0, 2, 8'd1);
        b3 = put(b3, 1, 0, 8'd1);   b3 = put(b3, 1, 1, 8'd1);
        b3 = put(b3, 2, 1, 8'hFF);  b3 = put(b3, 2, 2, 8'd5);
        r3 = put(r3, 0, 1, 8'hFB);  r3 = put(r3, 0, 2, 8'h10);
        r3 = put(r3, 1, 0, 8'h04);  r3 = put(r3, 1, 1, 8'h05);  r3 = put(r3, 1, 2, 8'hFB);
        r3 = put(r3, 2, 1, 8'hFE);  r3 = put(r3, 2, 2, 8'h8A);

        // Reset held together with start: reset wins, outputs idle.
        repeat (3) @(negedge clk);
        check("reset result", result_out, 200'(0));
        check("reset overflow", 200'(overflow_flag), 200'(0));
        check("reset busy", 200'(busy), 200'(0));
        check("reset done", 200'(done), 200'(0));
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post_reset busy", 200'(busy), 200'(0));

        launch("ident_n5", ident, btest, 3'd5, btest, 1'b0, 150);
        @(negedge clk);
        check("ident_n5 busy_early", 200'(busy), 200'(1));
        wait_done("ident_n5");

        launch("all127", all127, all127, 3'd5, res05, 1'b1, 150);
        wait_done("all127");

        launch("size0", ident, btest, 3'd0, btest, 1'b0, 150);
        wait_done("size0");

        launch("n2", a2, b2, 3'd2, r2, 1'b0, 12);
        wait_done("n2");

        launch("n1_neg", a1, b1, 3'd1, r1, 1'b1, 2);
        wait_done("n1_neg");

        launch("n3_mixed", a3, b3, 3'd3, r3, 1'b1, 36);
        wait_done("n3_mixed");

        // Re-pulse start at edge 30 with a different matrix_a; must be ignored.
        launch("repulse", ident, btest, 3'd5, btest, 1'b0, 150);
        wait_edge(start_edge + 29);
        start = 1'b1; matrix_a = all127; size = 3'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done("repulse");

        // Reset at edge 40 of a run aborts it; a fresh run then completes.
        launch("aborted", all127, all127, 3'd5, res05, 1'b1, 150);
        wait_edge(start_edge + 39);
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        check("abort result", result_out, 200'(0));
        check("abort overflow", 200'(overflow_flag), 200'(0));
        check("abort busy", 200'(busy), 200'(0));
        check("abort done", 200'(done), 200'(0));
        reset = 1'b0;
        launch("after_abort", a2, b2, 3'd2, r2, 1'b0, 12);
        wait_done("after_abort");

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
